// File: rtl/operand_streamer.sv
// Streams (feature-map, kernel) operand pairs for a sliding-window convolution.
// Reads are credit-limited so that at most two pairs are ever held or in flight.
module operand_streamer #(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 32,
    parameter int FEATURE_MAP_HEIGHT = 32,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                                                   clk,
    input  logic                                                   arst_n,
    input  logic                                                   start,
    input  logic [1:0]                                             conv_stride_mode,
    output logic                                                   running,
    output logic [DATA_WIDTH-1:0]                                  a_input,
    output logic [DATA_WIDTH-1:0]                                  b_input,
    output logic                                                   a_valid,
    input  logic                                                   a_ready,
    output logic                                                   fmap_re,
    output logic [$clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT)-1:0] fmap_addr,
    input  logic [DATA_WIDTH-1:0]                                  fmap_rdata,
    output logic                                                   kern_re,
    output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]             kern_addr,
    input  logic [DATA_WIDTH-1:0]                                  kern_rdata
);

    localparam int FA_W = $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT);
    localparam int KA_W = $clog2(KERNEL_SIZE*KERNEL_SIZE);
    localparam int XW   = $clog2(FEATURE_MAP_WIDTH+1);
    localparam int YW   = $clog2(FEATURE_MAP_HEIGHT+1);
    localparam int KW   = $clog2(KERNEL_SIZE+1);
    localparam int PW   = 2*DATA_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Stride is a power of two, so it is kept as a shift amount.
    function automatic logic [1:0] stride_shift(input logic [1:0] mode);
        logic [1:0] sh;
        case (mode)
            2'd0:    sh = 2'd0;
            2'd1:    sh = 2'd1;
            2'd2:    sh = 2'd2;
            2'd3:    sh = 2'd0;
            default: sh = 2'd0;
        endcase
        return sh;
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      shift_q, shift_d;
    logic [XW-1:0]   ox_q, ox_d;
    logic [YW-1:0]   oy_q, oy_d;
    logic [KW-1:0]   kx_q, kx_d;
    logic [KW-1:0]   ky_q, ky_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      count_q, count_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   slot0_q, slot0_d;
    logic [PW-1:0]   slot1_q, slot1_d;

    logic            pop_s, push_s, issue_s, last_tuple_s;
    logic [2:0]      room_s;
    logic [XW-1:0]   ox_last_s;
    logic [YW-1:0]   oy_last_s;
    logic [PW-1:0]   head_s;
    logic [FA_W-1:0] fmap_addr_s;
    logic [KA_W-1:0] kern_addr_s;

    assign ox_last_s    = XW'((FEATURE_MAP_WIDTH - KERNEL_SIZE) >> shift_q);
    assign oy_last_s    = YW'((FEATURE_MAP_HEIGHT - KERNEL_SIZE) >> shift_q);
    assign last_tuple_s = (oy_q == oy_last_s) && (ox_q == ox_last_s) &&
                          (ky_q == K_LAST) && (kx_q == K_LAST);

    // Credit counts the slot freed by a same-cycle pop so full throughput is kept.
    assign pop_s   = (count_q != 2'd0) && a_ready;
    assign push_s  = inflight_q;
    assign room_s  = {1'b0, count_q} - {2'b00, pop_s} + {2'b00, inflight_q};
    assign issue_s = (state_q == ST_RUN) && (room_s < 3'd2);

    assign fmap_addr_s = FA_W'((((32'(oy_q) << shift_q) + 32'(ky_q)) * 32'(FEATURE_MAP_WIDTH)) +
                               (32'(ox_q) << shift_q) + 32'(kx_q));
    assign kern_addr_s = KA_W'(32'(ky_q) * 32'(KERNEL_SIZE) + 32'(kx_q));

    assign fmap_re   = issue_s;
    assign kern_re   = issue_s;
    assign fmap_addr = issue_s ? fmap_addr_s : {FA_W{1'b0}};
    assign kern_addr = issue_s ? kern_addr_s : {KA_W{1'b0}};

    assign head_s  = rd_ptr_q ? slot1_q : slot0_q;
    assign a_input = head_s[PW-1:DATA_WIDTH];
    assign b_input = head_s[DATA_WIDTH-1:0];
    assign a_valid = (count_q != 2'd0);
    assign running = (state_q != ST_IDLE);

    assign inflight_d = issue_s;
    assign count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};
    assign rd_ptr_d   = rd_ptr_q ^ pop_s;
    assign wr_ptr_d   = wr_ptr_q ^ push_s;

    // Job sequencing and the oy/ox/ky/kx tap counters.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    shift_d = stride_shift(conv_stride_mode);
                    ox_d    = {XW{1'b0}};
                    oy_d    = {YW{1'b0}};
                    kx_d    = {KW{1'b0}};
                    ky_d    = {KW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    if (kx_q != K_LAST) begin
                        kx_d = kx_q + KW'(1);
                    end else begin
                        kx_d = {KW{1'b0}};
                        if (ky_q != K_LAST) begin
                            ky_d = ky_q + KW'(1);
                        end else begin
                            ky_d = {KW{1'b0}};
                            if (ox_q != ox_last_s) begin
                                ox_d = ox_q + XW'(1);
                            end else begin
                                ox_d = {XW{1'b0}};
                                oy_d = oy_q + YW'(1);
                            end
                        end
                    end
                    state_d = last_tuple_s ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Returning read data lands in the slot named by the write pointer.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (push_s && !wr_ptr_q) begin
            slot0_d = {fmap_rdata, kern_rdata};
        end else begin
            slot0_d = slot0_q;
        end
        if (push_s && wr_ptr_q) begin
            slot1_d = {fmap_rdata, kern_rdata};
        end else begin
            slot1_d = slot1_q;
        end
    end

    // State register; clearing inflight on reset drops any late read data.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 2'd0;
            ox_q       <= {XW{1'b0}};
            oy_q       <= {YW{1'b0}};
            kx_q       <= {KW{1'b0}};
            ky_q       <= {KW{1'b0}};
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            slot0_q    <= {PW{1'b0}};
            slot1_q    <= {PW{1'b0}};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
        end
    end

endmodule

// File: tb/tb_operand_streamer.sv
// Randomized bench for operand_streamer on a 5x5 map with a 3x3 kernel; expected
// read order and operand data come from a loop-nest model of the convolution.
module tb_operand_streamer;

    localparam int DW = 16;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int K  = 3;
    localparam int FA = $clog2(W*H);
    localparam int KA = $clog2(K*K);

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    conv_stride_mode = 2'd0;
    logic          running;
    logic [DW-1:0] a_input, b_input;
    logic          a_valid;
    logic          a_ready = 1'b0;
    logic          fmap_re, kern_re;
    logic [FA-1:0] fmap_addr;
    logic [KA-1:0] kern_addr;
    logic [DW-1:0] fmap_rdata = '0;
    logic [DW-1:0] kern_rdata = '0;

    operand_streamer #(
        .DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .conv_stride_mode(conv_stride_mode),
        .running(running), .a_input(a_input), .b_input(b_input), .a_valid(a_valid),
        .a_ready(a_ready), .fmap_re(fmap_re), .fmap_addr(fmap_addr), .fmap_rdata(fmap_rdata),
        .kern_re(kern_re), .kern_addr(kern_addr), .kern_rdata(kern_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memories; garbage on idle cycles exposes pushes without a read.
    logic [DW-1:0] fmem [W*H];
    logic [DW-1:0] kmem [K*K];
    always @(posedge clk) begin
        fmap_rdata <= fmap_re ? fmem[int'(fmap_addr)] : DW'($urandom);
        kern_rdata <= kern_re ? kmem[int'(kern_addr)] : DW'($urandom);
    end

    int checks = 0;
    int failures = 0;
    int rd_f[$], rd_k[$], exp_f[$], exp_k[$];
    logic [DW-1:0] xa[$], xb[$];
    int stall_bad, re_bad, max_out, first_valid, first_xfer, last_xfer, fall_cyc;
    bit timeout, last_run, rst_bad;

    task automatic fill_mem();
        for (int i = 0; i < W*H; i++) fmem[i] = DW'($urandom);
        for (int i = 0; i < K*K; i++) kmem[i] = DW'($urandom);
    endtask

    // Reference: plain loop nest over output pixels and kernel taps.
    task automatic build_exp(input int mode);
        int s, ow, oh;
        s  = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
        ow = (W - K) / s + 1;
        oh = (H - K) / s + 1;
        exp_f.delete();
        exp_k.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        exp_f.push_back((oy*s + ky)*W + ox*s + kx);
                        exp_k.push_back(ky*K + kx);
                    end
    endtask

    task automatic launch(input logic [1:0] mode);
        @(negedge clk);
        conv_stride_mode = mode;
        start = 1'b1;
    endtask

    // Records reads, transfers and stall behaviour until running falls (bounded).
    task automatic collect(input int rmode, input int restart_at, input int rst_at);
        int issued = 0, xfers = 0, low_cnt = 0;
        bit prev_stall = 1'b0, held = 1'b0, restarted = 1'b0, seen = 1'b0;
        logic [DW-1:0] pa = '0, pb = '0;
        rd_f.delete(); rd_k.delete(); xa.delete(); xb.delete();
        stall_bad = 0; re_bad = 0; max_out = 0; first_valid = -1;
        first_xfer = -1; last_xfer = -1; fall_cyc = -1;
        timeout = 1'b1; last_run = 1'b0; rst_bad = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (low_cnt > 0) begin a_ready = 1'b0; low_cnt--; end
            else if (rmode == 0) a_ready = 1'b1;
            else a_ready = 1'($urandom_range(0, 1));
            #1;
            if (rst_at >= 0 && xfers == rst_at) begin
                arst_n = 1'b0;
                #1;
                if ({running, a_valid, fmap_re, kern_re, a_input, b_input, fmap_addr, kern_addr} !== '0)
                    rst_bad = 1'b1;
                #1 arst_n = 1'b1;
                timeout = 1'b0;
                break;
            end
            if (first_valid < 0 && a_valid) first_valid = cyc;
            if (prev_stall && (a_valid !== 1'b1 || a_input !== pa || b_input !== pb)) stall_bad++;
            if (kern_re !== fmap_re) re_bad++;
            if (fmap_re) begin
                rd_f.push_back(int'(fmap_addr));
                rd_k.push_back(int'(kern_addr));
                issued++;
            end
            if (a_valid && a_ready) begin
                xa.push_back(a_input);
                xb.push_back(b_input);
                xfers++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                last_run = running;
            end
            prev_stall = a_valid && !a_ready;
            pa = a_input;
            pb = b_input;
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (restart_at >= 0 && !restarted && xfers == restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (rmode == 2 && !held && xfers == 30) begin low_cnt = 10; held = 1'b1; end
            if (running) seen = 1'b1;
            else if (seen) begin fall_cyc = cyc; timeout = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0; start = 1'b0; a_ready = 1'b1;
        #12;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%0b exp=0", running); end
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%0b exp=0", a_valid); end
        checks++; if ({fmap_re, kern_re} !== 2'b00) begin failures++; $display("FAIL reset_re got=%0b%0b exp=00", fmap_re, kern_re); end
        checks++; if (a_input !== '0) begin failures++; $display("FAIL reset_a_input got=%0h exp=0", a_input); end
        checks++; if (b_input !== '0) begin failures++; $display("FAIL reset_b_input got=%0h exp=0", b_input); end
        checks++; if (fmap_addr !== '0) begin failures++; $display("FAIL reset_fmap_addr got=%0d exp=0", fmap_addr); end
        checks++; if (kern_addr !== '0) begin failures++; $display("FAIL reset_kern_addr got=%0d exp=0", kern_addr); end
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({running, a_valid, fmap_re} !== 3'b000) begin
                failures++;
                $display("FAIL idle_after_reset got=%0b%0b%0b exp=000", running, a_valid, fmap_re);
            end
        end
    endtask

    task automatic test_stride_modes();
        int cnt_exp[4] = '{81, 36, 9, 81};
        int first9[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int bad;
        for (int m = 0; m < 4; m++) begin
            fill_mem();
            build_exp(m);
            launch(2'(m));
            collect(0, -1, -1);
            checks++; if (timeout) begin failures++; $display("FAIL mode%0d_timeout got=1 exp=0", m); end
            checks++; if (xa.size() != cnt_exp[m]) begin failures++; $display("FAIL mode%0d_xfer_count got=%0d exp=%0d", m, xa.size(), cnt_exp[m]); end
            checks++; if (rd_f.size() != exp_f.size()) begin failures++; $display("FAIL mode%0d_read_count got=%0d exp=%0d", m, rd_f.size(), exp_f.size()); end
            bad = 0;
            for (int i = 0; i < rd_f.size() && i < exp_f.size(); i++)
                if (rd_f[i] != exp_f[i] || rd_k[i] != exp_k[i]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL mode%0d_read_order got=%0d_bad exp=0", m, bad); end
            bad = 0;
            for (int i = 0; i < xa.size() && i < exp_f.size(); i++)
                if (xa[i] !== fmem[exp_f[i]] || xb[i] !== kmem[exp_k[i]]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL mode%0d_data got=%0d_bad exp=0", m, bad); end
            checks++; if (first_valid != 2) begin failures++; $display("FAIL mode%0d_latency got=%0d exp=2", m, first_valid); end
            checks++; if (last_xfer - first_xfer != cnt_exp[m] - 1) begin failures++; $display("FAIL mode%0d_throughput got=%0d exp=%0d", m, last_xfer - first_xfer, cnt_exp[m] - 1); end
            checks++; if (!last_run || fall_cyc - last_xfer < 1 || fall_cyc - last_xfer > 3) begin
                failures++; $display("FAIL mode%0d_running_fall got=%0d exp=1..3", m, fall_cyc - last_xfer); end
            checks++; if (max_out > 2 || re_bad != 0) begin failures++; $display("FAIL mode%0d_outstanding got=%0d/%0d exp=<=2/0", m, max_out, re_bad); end
            if (m == 0 && rd_f.size() >= 9) begin
                bad = 0;
                for (int i = 0; i < 9; i++) if (rd_f[i] != first9[i] || rd_k[i] != i) bad++;
                checks++; if (bad != 0) begin failures++; $display("FAIL first_nine_addr got=%0d_bad exp=0", bad); end
            end
            if (m == 1 && rd_f.size() >= 10) begin
                checks++; if (rd_f[9] != 2 || rd_k[9] != 0) begin
                    failures++; $display("FAIL stride2_tenth got=%0d/%0d exp=2/0", rd_f[9], rd_k[9]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        fill_mem();
        build_exp(0);
        launch(2'd0);
        collect(2, -1, -1);
        checks++; if (timeout || xa.size() != 81) begin failures++; $display("FAIL bp_count got=%0d exp=81", xa.size()); end
        bad = 0;
        for (int i = 0; i < rd_f.size() && i < exp_f.size(); i++) if (rd_f[i] != exp_f[i] || rd_k[i] != exp_k[i]) bad++;
        for (int i = 0; i < xa.size() && i < exp_f.size(); i++) if (xa[i] !== fmem[exp_f[i]] || xb[i] !== kmem[exp_k[i]]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_sequence got=%0d_bad exp=0", bad); end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
        checks++; if (max_out > 2) begin failures++; $display("FAIL bp_outstanding got=%0d exp=<=2", max_out); end
    endtask

    task automatic test_restart_ignored();
        int bad;
        fill_mem();
        build_exp(0);
        for (int j = 0; j < 2; j++) begin
            launch(2'd0);
            collect(1, (j == 0) ? 20 : -1, -1);
            checks++; if (timeout || xa.size() != 81) begin failures++; $display("FAIL restart_job%0d_count got=%0d exp=81", j, xa.size()); end
            bad = 0;
            for (int i = 0; i < xa.size() && i < exp_f.size(); i++) if (xa[i] !== fmem[exp_f[i]] || xb[i] !== kmem[exp_k[i]]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL restart_job%0d_data got=%0d_bad exp=0", j, bad); end
        end
    endtask

    task automatic test_reset_midjob();
        int bad;
        fill_mem();
        build_exp(0);
        launch(2'd0);
        collect(0, -1, 40);
        checks++; if (timeout || xa.size() != 40) begin failures++; $display("FAIL midrst_reached got=%0d exp=40", xa.size()); end
        checks++; if (rst_bad) begin failures++; $display("FAIL midrst_outputs_zero got=1 exp=0"); end
        a_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if ({running, a_valid, fmap_re, kern_re} !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL midrst_quiet got=%0d_active exp=0", bad); end
        launch(2'd0);
        collect(1, -1, -1);
        checks++; if (timeout || xa.size() != 81) begin failures++; $display("FAIL midrst_newjob_count got=%0d exp=81", xa.size()); end
        bad = 0;
        for (int i = 0; i < xa.size() && i < exp_f.size(); i++) if (xa[i] !== fmem[exp_f[i]] || xb[i] !== kmem[exp_k[i]]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL midrst_newjob_data got=%0d_bad exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_stride_modes();
        test_backpressure();
        test_restart_ignored();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/operand_streamer.md
OPERAND_STREAMER -- requirements
Module: operand_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, operand width in bits.
REQ-002 SHALL have parameter FEATURE_MAP_WIDTH, 32, feature-map columns W.
REQ-003 SHALL have parameter FEATURE_MAP_HEIGHT, 32, feature-map rows H.
REQ-004 SHALL have parameter KERNEL_SIZE, 3, kernel side K; K <= W and K <= H.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle start pulse.
REQ-008 SHALL have port conv_stride_mode, input, 2, stride select: 0->1, 1->2, 2->4, 3->1.
REQ-009 SHALL have port running, output, 1, high while a job is active.
REQ-010 SHALL have port a_input, output, DATA_WIDTH, feature-map operand.
REQ-011 SHALL have port b_input, output, DATA_WIDTH, kernel operand.
REQ-012 SHALL have port a_valid, output, 1, operand pair valid.
REQ-013 SHALL have port a_ready, input, 1, consumer accepts the pair.
REQ-014 SHALL have port fmap_re, output, 1, feature-map memory read enable.
REQ-015 SHALL have port fmap_addr, output, $clog2(W*H), feature-map word address (row-major).
REQ-016 SHALL have port fmap_rdata, input, DATA_WIDTH, read data, valid exactly 1 cycle after fmap_re.
REQ-017 SHALL have port kern_re, output, 1, kernel memory read enable; always equal to fmap_re.
REQ-018 SHALL have port kern_addr, output, $clog2(K*K), kernel word address (row-major).
REQ-019 SHALL have port kern_rdata, input, DATA_WIDTH, read data, valid exactly 1 cycle after kern_re.

Function
REQ-020 SHALL implement FSM IDLE, RUN, DRAIN; running = (state != IDLE).
REQ-021 IDLE: start=1 SHALL latch stride S, clear counters, enter RUN next cycle; start in RUN/DRAIN SHALL be ignored.
REQ-022 SHALL generate reads in loop order oy (outer), ox, ky, kx (inner), with OUT_W=(W-K)/S+1, OUT_H=(H-K)/S+1 (integer division).
REQ-023 Read address SHALL be fmap_addr=(oy*S+ky)*W+(ox*S+kx), kern_addr=ky*K+kx.
REQ-024 SHALL hold read data in a 2-entry FIFO; a read SHALL be issued only when (FIFO occupancy + reads in flight) < 2.
REQ-025 a_valid SHALL equal FIFO non-empty; a_input/b_input SHALL be the FIFO head pair.
REQ-026 A transfer SHALL occur iff a_valid && a_ready; it pops the head; simultaneous pop and arrival of read data SHALL be legal with no loss or duplication.
REQ-027 While a_valid=1 and a_ready=0, a_input, b_input, a_valid SHALL remain stable.
REQ-028 With a_ready held 1, SHALL sustain one transfer per cycle after a 2-cycle initial latency (start -> first a_valid).
REQ-029 Issuing the read for the last tuple (oy=OUT_H-1, ox=OUT_W-1, ky=kx=K-1) SHALL move RUN->DRAIN.
REQ-030 DRAIN SHALL return to IDLE in the cycle after the FIFO is empty with no read in flight; total transfers per job SHALL be OUT_W*OUT_H*K*K exactly.
REQ-031 fmap_re/kern_re SHALL be 0 in IDLE and DRAIN.

Reset
REQ-032 arst_n=0 SHALL immediately force state IDLE, FIFO empty, counters 0, running=0, a_valid=0, fmap_re=kern_re=0, a_input=b_input=0, fmap_addr=kern_addr=0.
REQ-033 Reset mid-job SHALL abandon the job; in-flight read data returning after reset release SHALL be discarded.
REQ-034 After reset release, no read or transfer SHALL occur until a new start.

Verification
REQ-035 W=H=5, K=3, mode 0, a_ready=1 -> 81 transfers; first nine fmap_addr 0,1,2,5,6,7,10,11,12 with kern_addr 0..8; running falls after the 81st.
REQ-036 W=H=5, K=3, mode 1 -> 36 transfers; the 10th transfer (first tap of pixel 2) uses fmap_addr 2, kern_addr 0; mode 3 -> identical to mode 0.
REQ-037 a_ready toggled randomly / held low 10 cycles mid-stream -> data stable while stalled, sequence identical to REQ-035, no gaps or duplicates, never more than 2 reads outstanding.
REQ-038 start pulsed again at transfer 20 -> ignored; still exactly 81 transfers, then a new start runs a full second job.
REQ-039 arst_n asserted at transfer 40 -> all outputs 0 that cycle; after release, no activity until start; a new job produces 81 correct transfers.
